// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter that shares a 2-to-1 mux path between requesters A and B.
// It drives the mux select and one-hot grants, and bounds how long one side can
// hold the path while the other side waits.
module mux_2x1_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned   CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  state_t        state;
  side_t         last;
  logic [CW-1:0] hold_cnt;

  // Arbitration FSM; grants and sel are registered and change with the state.
  // Leaving a grant records that side in last, so a tie from IDLE goes to the
  // other side; a handover goes straight to the other grant with no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= SIDE_B;
      hold_cnt <= '0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
      sel      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_a && (!req_b || last == SIDE_B)) begin
            state    <= GNT_A;
            grant_a  <= 1'b1;
            grant_b  <= 1'b0;
            sel      <= 1'b0;
            hold_cnt <= '0;
          end else if (req_b) begin
            state    <= GNT_B;
            grant_a  <= 1'b0;
            grant_b  <= 1'b1;
            sel      <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GNT_A: begin
          if (!req_a || (req_b && hold_cnt == HOLD_LAST)) begin
            last <= SIDE_A;
            if (req_b) begin
              state    <= GNT_B;
              grant_a  <= 1'b0;
              grant_b  <= 1'b1;
              sel      <= 1'b1;
              hold_cnt <= '0;
            end else begin
              state   <= IDLE;
              grant_a <= 1'b0;
              grant_b <= 1'b0;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GNT_B: begin
          if (!req_b || (req_a && hold_cnt == HOLD_LAST)) begin
            last <= SIDE_B;
            if (req_a) begin
              state    <= GNT_A;
              grant_a  <= 1'b1;
              grant_b  <= 1'b0;
              sel      <= 1'b0;
              hold_cnt <= '0;
            end else begin
              state   <= IDLE;
              grant_a <= 1'b0;
              grant_b <= 1'b0;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
        end
      endcase
    end
  end

  // Shared output path: data follows sel combinationally.
  always_comb begin
    out_valid = grant_a | grant_b;
    out_data  = sel ? data_b : data_a;
  end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Scoreboard bench for mux_2x1_arbiter: a MAX_HOLD=4 instance for the main
// scenarios and a MAX_HOLD=1 instance for strict alternation.
module tb_mux_2x1_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b, req1_a, req1_b;
  logic [7:0] data_a, data_b;
  logic       grant_a, grant_b, sel, out_valid;
  logic [7:0] out_data;
  logic       g1_a, g1_b, sel1, valid1;
  logic [7:0] data1;

  typedef struct {
    logic       ga;
    logic       gb;
    logic       sel;
    logic [7:0] data;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  mux_2x1_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .grant_a(grant_a), .grant_b(grant_b),
    .sel(sel), .out_valid(out_valid), .out_data(out_data)
  );

  mux_2x1_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req1_a), .req_b(req1_b),
    .data_a(data_a), .data_b(data_b), .grant_a(g1_a), .grant_b(g1_b),
    .sel(sel1), .out_valid(valid1), .out_data(data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: after every active edge, pop the expected response and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".grant_a"}, {7'd0, grant_a}, {7'd0, e.ga});
      chk({e.tag, ".grant_b"}, {7'd0, grant_b}, {7'd0, e.gb});
      chk({e.tag, ".sel"}, {7'd0, sel}, {7'd0, e.sel});
      chk({e.tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e.ga | e.gb});
      if (e.ga | e.gb) chk({e.tag, ".out_data"}, out_data, e.data);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({e.tag, ".grant_a"}, {7'd0, g1_a}, {7'd0, e.ga});
      chk({e.tag, ".grant_b"}, {7'd0, g1_b}, {7'd0, e.gb});
      chk({e.tag, ".sel"}, {7'd0, sel1}, {7'd0, e.sel});
      chk({e.tag, ".out_valid"}, {7'd0, valid1}, {7'd0, e.ga | e.gb});
    end
  end

  // Drive requests for the next edge on the MAX_HOLD=4 instance and queue
  // the grant state expected right after that edge.
  task automatic step(input string tag, input logic ra, input logic rb,
                      input logic ega, input logic egb, input logic esel);
    exp_t e;
    @(negedge clk);
    req_a = ra;
    req_b = rb;
    e.ga = ega; e.gb = egb; e.sel = esel;
    e.data = esel ? 8'hC3 : 8'h5A;
    e.tag = tag;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic step1(input string tag, input logic ra, input logic rb,
                       input logic ega, input logic egb, input logic esel);
    exp_t e;
    @(negedge clk);
    req1_a = ra;
    req1_b = rb;
    e.ga = ega; e.gb = egb; e.sel = esel;
    e.data = esel ? 8'hC3 : 8'h5A;
    e.tag = tag;
    q1.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    req_a  = 1'b0; req_b  = 1'b0;
    req1_a = 1'b0; req1_b = 1'b0;
    data_a = 8'h5A;
    data_b = 8'hC3;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.grant_a", {7'd0, grant_a}, 8'd0);
    chk("rst.grant_b", {7'd0, grant_b}, 8'd0);
    chk("rst.sel", {7'd0, sel}, 8'd0);
    chk("rst.out_valid", {7'd0, out_valid}, 8'd0);
    rst_n = 1'b1;

    // Lone requester A keeps the grant for 10 cycles, then releases to IDLE.
    for (int i = 0; i < 10; i++) step("single_a", 1, 0, 1, 0, 0);
    step("release_a", 0, 0, 0, 0, 0);

    // Last grant was A, so a tie from IDLE goes to B first.
    step("rr_memory", 1, 1, 0, 1, 1);
    // Both continuously requesting: B x4 (incl. above), A x4, B x4.
    for (int i = 0; i < 3; i++) step("fair_b1", 1, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("fair_a", 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("fair_b2", 1, 1, 0, 1, 1);

    // B drops, A takes over; then A drops mid-grant with B waiting.
    step("b_release", 1, 0, 1, 0, 0);
    step("a_hold", 1, 0, 1, 0, 0);
    step("handover", 0, 1, 0, 1, 1);
    step("to_idle", 0, 0, 0, 0, 1);
    step("idle_sel_hold", 0, 0, 0, 0, 1);

    // Reset mid-GNT_B drops outputs without a clock edge.
    step("pre_rst_b", 0, 1, 0, 1, 1);
    #3;
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    #1;
    chk("async_rst.grant_b", {7'd0, grant_b}, 8'd0);
    chk("async_rst.sel", {7'd0, sel}, 8'd0);
    chk("async_rst.out_valid", {7'd0, out_valid}, 8'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_tie", 1, 1, 1, 0, 0);
    step("post_rst_idle", 0, 0, 0, 0, 0);

    // MAX_HOLD=1 instance: strict alternation, A first after reset.
    for (int i = 0; i < 3; i++) begin
      step1("mh1_a", 1, 1, 1, 0, 0);
      step1("mh1_b", 1, 1, 0, 1, 1);
    end
    step1("mh1_idle", 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 8'(q.size() + q1.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
